// File: rtl/uart_rx.sv
// uart_rx: recovers 8E1 frames (start, 8 data LSB first, even parity, stop) from a serial line.
// Define UART_RX_SYNC_EN to pass data_in through a two-flop synchronizer before sampling.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [TW-1:0] HALF_LOAD = (HALF > 0) ? TW'(HALF - 1) : '0;
   localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t        state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic [2:0]    bit_cnt, bit_next;
   logic [7:0]    shift, shift_next;
   logic          par_bit, par_next;
   logic          stop_edge;
   logic          rxs;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], data_in};
      end
   end

   assign rxs = sync[1];
`else
   assign rxs = data_in;
`endif

   // Timer counts down to zero; each zero is one mid-bit sampling edge
   always_comb begin
      state_next = state;
      timer_next = timer;
      bit_next   = bit_cnt;
      shift_next = shift;
      par_next   = par_bit;
      stop_edge  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rxs) begin
               bit_next = 3'd0;
               if (HALF == 0) begin
                  state_next = DATA;
                  timer_next = BIT_LOAD;
               end else begin
                  state_next = START;
                  timer_next = HALF_LOAD;
               end
            end
         end
         START: begin
            if (timer == '0) begin
               if (rxs) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  timer_next = BIT_LOAD;
               end
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         DATA: begin
            if (timer == '0) begin
               shift_next = {rxs, shift[7:1]};
               timer_next = BIT_LOAD;
               if (bit_cnt == 3'd7) begin
                  state_next = PARITY;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         PARITY: begin
            if (timer == '0) begin
               par_next   = rxs;
               timer_next = BIT_LOAD;
               state_next = STOP;
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         STOP: begin
            if (timer == '0) begin
               stop_edge  = 1'b1;
               timer_next = '0;
               state_next = rxs ? IDLE : BREAK;
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         BREAK: begin
            if (rxs) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   // State, datapath and result registers; results update only on the stop edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         bit_cnt    <= 3'd0;
         shift      <= 8'h00;
         par_bit    <= 1'b0;
         data_out   <= 8'h00;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         par_bit <= par_next;
         valid   <= stop_edge;
         if (stop_edge) begin
            data_out   <= shift;
            parity_err <= (^shift) ^ par_bit;
            frame_err  <= ~rxs;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a scoreboard of expected frames,
// one receiver at CLKS_PER_BIT=1 and one at CLKS_PER_BIT=16 sharing clock and reset.
module tb_uart_rx;

   localparam int CPB_A = 1;
   localparam int CPB_B = 16;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_a = 1'b1;
   logic       line_b = 1'b1;
   logic [7:0] dout_a, dout_b;
   logic       valid_a, valid_b;
   logic       perr_a, perr_b;
   logic       ferr_a, ferr_b;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         e0_a = 0;
   int         strobes_a = 0;
   int         strobes_b = 0;
   int         last_a = 0;
   int         cyc_b[$];
   logic [9:0] q_a[$];
   logic [9:0] q_b[$];

   uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .rst(rst), .data_in(line_a), .data_out(dout_a),
      .valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a)
   );

   uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
      .clk(clk), .rst(rst), .data_in(line_b), .data_out(dout_b),
      .valid(valid_b), .parity_err(perr_b), .frame_err(ferr_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every strobe must match the oldest outstanding expected frame
   always @(negedge clk) begin
      if (valid_a) begin
         strobes_a++;
         last_a = cyc;
         checkOutput("a strobe expected", q_a.size() > 0, 1);
         if (q_a.size() > 0) begin
            logic [9:0] e;
            e = q_a.pop_front();
            checkOutput("a data_out", dout_a, e[9:2]);
            checkOutput("a parity_err", perr_a, e[1]);
            checkOutput("a frame_err", ferr_a, e[0]);
         end
      end
      if (valid_b) begin
         strobes_b++;
         cyc_b.push_back(cyc);
         checkOutput("b strobe expected", q_b.size() > 0, 1);
         if (q_b.size() > 0) begin
            logic [9:0] e;
            e = q_b.pop_front();
            checkOutput("b data_out", dout_b, e[9:2]);
            checkOutput("b parity_err", perr_b, e[1]);
            checkOutput("b frame_err", ferr_b, e[0]);
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic driveLine(input bit on_b, input logic b);
      if (on_b) line_b = b;
      else line_a = b;
   endtask

   // Sends one frame; the expected result is queued before the first bit is driven
   task automatic applyStimulus(input bit on_b, input logic [7:0] d, input logic par,
                                input logic stp, input int stop_len,
                                input logic exp_perr, input logic exp_ferr);
      int cpb;
      cpb = on_b ? CPB_B : CPB_A;
      if (on_b) q_b.push_back({d, exp_perr, exp_ferr});
      else begin
         q_a.push_back({d, exp_perr, exp_ferr});
         e0_a = cyc + 1;
      end
      driveLine(on_b, 1'b0);
      hold(cpb);
      for (int k = 0; k < 8; k++) begin
         driveLine(on_b, d[k]);
         hold(cpb);
      end
      driveLine(on_b, par);
      hold(cpb);
      driveLine(on_b, stp);
      hold(stop_len);
   endtask

   initial begin
      int s;
      int n;
      logic [7:0] abort_byte;
      abort_byte = 8'h7E;

      #1;
      checkOutput("reset b data_out", dout_b, 8'h00);
      checkOutput("reset b valid", valid_b, 1'b0);
      checkOutput("reset b parity_err", perr_b, 1'b0);
      checkOutput("reset b frame_err", ferr_b, 1'b0);
      hold(3);
      rst = 1'b0;
      hold(4);

      // Single-clock bits: A5 with correct parity, strobe timing relative to the start edge
      s = strobes_a;
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      hold(4);
      checkOutput("a5 strobe count", strobes_a - s, 1);
      checkOutput("a5 strobe cycle", last_a, e0_a + 10 + SYNC_LAT);

      // Parity error flagged but frame still delivered
      s = strobes_b;
      applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1, CPB_B, 1'b1, 1'b0);
      hold(2);
      checkOutput("3c strobe count", strobes_b - s, 1);

      // Framing error followed by a held-low line, then recovery
      s = strobes_b;
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, CPB_B, 1'b0, 1'b1);
      hold(100);
      checkOutput("break single strobe", strobes_b - s, 1);
      line_b = 1'b1;
      hold(20);
      applyStimulus(1'b1, 8'h12, 1'b0, 1'b1, CPB_B, 1'b0, 1'b0);
      hold(2);
      checkOutput("after break strobes", strobes_b - s, 2);

      // Short low glitch rejected by the half-bit re-check
      s = strobes_b;
      line_b = 1'b0;
      hold(4);
      line_b = 1'b1;
      hold(40);
      checkOutput("glitch no strobe", strobes_b - s, 0);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, CPB_B, 1'b0, 1'b0);
      hold(2);
      checkOutput("ff strobe count", strobes_b - s, 1);

      // Back-to-back frames: full stop bit, then a stop bit cut to end right after the stop edge
      s = strobes_b;
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, CPB_B, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hFE, 1'b1, 1'b1, CPB_B / 2 + 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h81, 1'b0, 1'b1, CPB_B, 1'b0, 1'b0);
      hold(2);
      checkOutput("b2b strobe count", strobes_b - s, 3);
      n = cyc_b.size();
      if (n >= 3) begin
         checkOutput("b2b full stop spacing", cyc_b[n-2] - cyc_b[n-3], 11 * CPB_B);
         checkOutput("b2b short stop spacing", cyc_b[n-1] - cyc_b[n-2], 10 * CPB_B + CPB_B / 2 + 1);
      end else begin
         checkOutput("b2b strobe history", n, 3);
      end

      // Reset during data bit 4 aborts the frame without a strobe
      s = strobes_b;
      line_b = 1'b0;
      hold(CPB_B);
      for (int k = 0; k < 4; k++) begin
         line_b = abort_byte[k];
         hold(CPB_B);
      end
      line_b = abort_byte[4];
      hold(5);
      rst = 1'b1;
      #1;
      checkOutput("abort b data_out", dout_b, 8'h00);
      checkOutput("abort b valid", valid_b, 1'b0);
      checkOutput("abort b parity_err", perr_b, 1'b0);
      checkOutput("abort b frame_err", ferr_b, 1'b0);
      checkOutput("abort a data_out", dout_a, 8'h00);
      line_b = 1'b1;
      hold(2);
      rst = 1'b0;
      hold(20);
      checkOutput("abort no strobe", strobes_b - s, 0);
      applyStimulus(1'b1, 8'h7E, 1'b0, 1'b1, CPB_B, 1'b0, 1'b0);
      hold(2);
      checkOutput("7e strobe count", strobes_b - s, 1);

      hold(5);
      checkOutput("a scoreboard drained", q_a.size(), 0);
      checkOutput("b scoreboard drained", q_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
